// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digits
// and the 3-bit window recoder.
package booth_pkg;

  // Controller states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Radix-4 Booth digit selected by one 3-bit window of the multiplier
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PY   = 3'd1,
    P2Y  = 3'd2,
    MY   = 3'd3,
    M2Y  = 3'd4
  } digit_e;

  // Map the window {x[2i+1], x[2i], x[2i-1]} to its Booth digit
  function automatic digit_e booth_recode(input logic [2:0] win);
    digit_e d;
    case (win)
      3'b001, 3'b010: d = PY;
      3'b011:         d = P2Y;
      3'b100:         d = M2Y;
      3'b101, 3'b110: d = MY;
      default:        d = ZERO;  // 000 and 111
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Combinational partial-product generator: turns one Booth window and the
// (W+2)-bit extended multiplicand into a (W+3)-bit signed partial product.
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   win_i,
  input  logic [W+1:0] y_ext_i,
  output logic [W+2:0] pp_o
);

  digit_e       digit;
  logic [W+2:0] y1;
  logic [W+2:0] y2;

  assign digit = booth_recode(win_i);

  // +Y and +2Y at partial-product width; Y is already signed at W+2 bits,
  // so one more sign bit makes room for the doubled value.
  assign y1 = {y_ext_i[W+1], y_ext_i};
  assign y2 = {y_ext_i, 1'b0};

  // Select the signed multiple of Y for this digit
  always_comb begin
    pp_o = '0;
    case (digit)
      PY:      pp_o = y1;
      P2Y:     pp_o = y2;
      MY:      pp_o = -y1;
      M2Y:     pp_o = -y2;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_r4.sv
// Sequential radix-4 Booth multiplier: W x W -> 2W, signed or unsigned per
// operation, two multiplier bits retired per clock behind start/busy/valid.
module booth_mul_r4
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           tc,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
  output logic           busy,
  output logic           valid,
  output logic [2*W-1:0] Z
);

  // Operands are widened by two bits so unsigned values are positive when
  // viewed as signed and the digit count covers every multiplier bit.
  localparam int XW = W + 2;
  localparam int D  = W / 2 + 1;
  localparam int AW = 2 * XW + 1;
  localparam int CW = $clog2(D);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [XW-1:0]    y_q, y_d;
  logic             valid_q, valid_d;
  logic [2*W-1:0]   z_q, z_d;

  logic             load;
  logic             step;
  logic             last;
  logic [XW-1:0]    x_ext;
  logic [XW-1:0]    y_ext;
  logic [W+2:0]     pp;
  logic [W+2:0]     sum;
  logic [AW-1:0]    shifted;

  assign x_ext = {{2{tc & X[W-1]}}, X};
  assign y_ext = {{2{tc & Y[W-1]}}, Y};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only matters in IDLE, RUN leaves after the last digit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag and datapath controls
  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    step = 1'b0;
    last = 1'b0;
    case (state_q)
      IDLE: begin
        load = start;
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        last = (count_q == CW'(D - 1));
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  booth_r4_digit #(
    .W(W)
  ) u_digit (
    .win_i  (acc_q[2:0]),
    .y_ext_i(y_q),
    .pp_o   (pp)
  );

  // The running partial sum lives above the multiplier field; it is widened
  // by one sign bit so the addition cannot overflow, and after the 2-bit
  // arithmetic shift the dropped top bit is only a redundant sign copy.
  assign sum     = {acc_q[AW-1], acc_q[AW-1:XW+1]} + pp;
  assign shifted = {sum[W+2], sum, acc_q[XW:2]};

  // Datapath next-state: load on accept, add-and-shift in RUN, capture product on the last digit
  always_comb begin
    acc_d   = acc_q;
    y_d     = y_q;
    count_d = count_q;
    z_d     = z_q;
    valid_d = 1'b0;
    if (load) begin
      y_d     = y_ext;
      acc_d   = {{XW{1'b0}}, x_ext, 1'b0};
      count_d = '0;
    end else if (step) begin
      acc_d = shifted;
      if (last) begin
        count_d = '0;
        z_d     = shifted[2*W:1];
        valid_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      y_q     <= '0;
      count_q <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      y_q     <= y_d;
      count_q <= count_d;
      z_q     <= z_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  assign Z     = z_q;

endmodule

// File: tb/tb_booth_mul_r4.sv
// Self-checking bench for booth_mul_r4: W=8 directed table plus handshake
// corner cases, and a W=16 random run against a behavioural product.
module tb_booth_mul_r4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  // W=8 instance
  logic        rst8, start8, tc8, busy8, valid8;
  logic [7:0]  x8, y8;
  logic [15:0] z8;

  // W=16 instance
  logic        rst16, start16, tc16, busy16, valid16;
  logic [15:0] x16, y16;
  logic [31:0] z16;

  booth_mul_r4 #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .tc(tc8), .X(x8), .Y(y8),
    .busy(busy8), .valid(valid8), .Z(z8)
  );

  booth_mul_r4 #(.W(16)) u_dut16 (
    .clk(clk), .rst(rst16), .start(start16), .tc(tc16), .X(x16), .Y(y16),
    .busy(busy16), .valid(valid16), .Z(z16)
  );

  typedef struct {
    logic [31:0] z;
    int          due;
  } sb_t;

  sb_t q8[$];
  sb_t q16[$];
  int  nvalid8  = 0;
  int  nvalid16 = 0;
  int  blen8    = 0;
  int  blen16   = 0;

  typedef struct {
    bit          tc;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref16(input bit t, input logic [15:0] a, input logic [15:0] b);
    longint pa, pb, p;
    if (t) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    p = pa * pb;
    return p[31:0];
  endfunction

  // Scoreboard for the W=8 unit
  always @(negedge clk) begin
    if (rst8) begin
      blen8 = 0;
    end else begin
      if (valid8) begin
        nvalid8++;
        check("valid_while_busy8", busy8, 0);
        if (q8.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid8: got valid=1 Z=0x%0h, required no pending product", z8);
        end else begin
          sb_t e;
          e = q8.pop_front();
          check("product8", z8, e.z);
          check("latency8", cyc, e.due);
          $display("W8  result Z=0x%04h expected 0x%04h at cycle %0d", z8, e.z[15:0], cyc);
        end
      end
      if (busy8) begin
        blen8++;
      end else if (blen8 != 0) begin
        check("busy_len8", blen8, 5);
        blen8 = 0;
      end
    end
  end

  // Scoreboard for the W=16 unit
  always @(negedge clk) begin
    if (rst16) begin
      blen16 = 0;
    end else begin
      if (valid16) begin
        nvalid16++;
        check("valid_while_busy16", busy16, 0);
        if (q16.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid16: got valid=1 Z=0x%0h, required no pending product", z16);
        end else begin
          sb_t e;
          e = q16.pop_front();
          check("product16", z16, e.z);
          check("latency16", cyc, e.due);
        end
      end
      if (busy16) begin
        blen16++;
      end else if (blen16 != 0) begin
        check("busy_len16", blen16, 9);
        blen16 = 0;
      end
    end
  end

  task automatic issue8(input bit t, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] z, input bit expect_it);
    int g = 0;
    while (busy8 && g < 50) begin
      tick();
      g++;
    end
    check("issue8_idle", busy8, 0);
    tc8 = t; x8 = a; y8 = b; start8 = 1'b1;
    if (expect_it) q8.push_back('{z: 32'(z), due: cyc + 1 + 5});
    $display("W8  start tc=%0d X=0x%02h Y=0x%02h at cycle %0d", t, a, b, cyc);
    tick();
    start8 = 1'b0;
  endtask

  task automatic issue16(input bit t, input logic [15:0] a, input logic [15:0] b);
    int g = 0;
    while (busy16 && g < 50) begin
      tick();
      g++;
    end
    check("issue16_idle", busy16, 0);
    tc16 = t; x16 = a; y16 = b; start16 = 1'b1;
    q16.push_back('{z: ref16(t, a, b), due: cyc + 1 + 9});
    tick();
    start16 = 1'b0;
  endtask

  task automatic drain8();
    int g = 0;
    while (q8.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    check("drain8", q8.size(), 0);
    tick();
  endtask

  task automatic drain16();
    int g = 0;
    while (q16.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    check("drain16", q16.size(), 0);
    tick();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[10];
    int   nv;

    tbl[0] = '{tc: 1'b1, x: 8'h80, y: 8'h80, z: 16'h4000};
    tbl[1] = '{tc: 1'b0, x: 8'hFF, y: 8'hFF, z: 16'hFE01};
    tbl[2] = '{tc: 1'b1, x: 8'hFF, y: 8'hFF, z: 16'h0001};
    tbl[3] = '{tc: 1'b1, x: 8'hFF, y: 8'h7F, z: 16'hFF81};
    tbl[4] = '{tc: 1'b1, x: 8'h03, y: 8'hFB, z: 16'hFFF1};
    tbl[5] = '{tc: 1'b0, x: 8'h00, y: 8'hFF, z: 16'h0000};
    tbl[6] = '{tc: 1'b1, x: 8'h7F, y: 8'h7F, z: 16'h3F01};
    tbl[7] = '{tc: 1'b1, x: 8'h80, y: 8'h7F, z: 16'hC080};
    tbl[8] = '{tc: 1'b0, x: 8'h80, y: 8'h80, z: 16'h4000};
    tbl[9] = '{tc: 1'b0, x: 8'h0C, y: 8'h0A, z: 16'h0078};

    rst8 = 1'b1; start8 = 1'b0; tc8 = 1'b0; x8 = '0; y8 = '0;
    rst16 = 1'b1; start16 = 1'b0; tc16 = 1'b0; x16 = '0; y16 = '0;
    repeat (3) tick();
    check("rst_busy8", busy8, 0);
    check("rst_valid8", valid8, 0);
    check("rst_z8", z8, 0);
    check("rst_busy16", busy16, 0);
    check("rst_valid16", valid16, 0);
    check("rst_z16", z16, 0);
    rst8 = 1'b0;
    rst16 = 1'b0;
    tick();

    // Table vectors, issued back-to-back on each valid cycle
    for (int i = 0; i < 10; i++) begin
      issue8(tbl[i].tc, tbl[i].x, tbl[i].y, tbl[i].z, 1'b1);
    end
    drain8();

    // start during RUN must be ignored
    nv = nvalid8;
    issue8(1'b1, 8'hFF, 8'h7F, 16'hFF81, 1'b1);
    tick();
    tc8 = 1'b1; x8 = 8'h03; y8 = 8'hFB; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    drain8();
    repeat (12) tick();
    check("ignored_start_valids", nvalid8 - nv, 1);
    check("z_hold8", z8, 16'hFF81);

    // Reset at count=2 aborts without a valid pulse
    issue8(1'b0, 8'd200, 8'd100, 16'h0000, 1'b0);
    tick();
    check("z_during_run8", z8, 16'hFF81);
    check("busy_during_run8", busy8, 1);
    tick();
    rst8 = 1'b1;
    tick();
    check("abort_busy8", busy8, 0);
    check("abort_valid8", valid8, 0);
    check("abort_z8", z8, 0);
    rst8 = 1'b0;
    nv = nvalid8;
    repeat (12) tick();
    check("abort_no_valid8", nvalid8 - nv, 0);
    check("abort_z_stays8", z8, 0);

    // rst wins over start in the same cycle
    rst8 = 1'b1; start8 = 1'b1; tc8 = 1'b1; x8 = 8'h05; y8 = 8'h05;
    tick();
    rst8 = 1'b0; start8 = 1'b0;
    check("rst_over_start_busy8", busy8, 0);
    tick();
    check("rst_over_start_idle8", busy8, 0);

    // Recovery after reset
    issue8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
    drain8();

    // W=16: corners, then random signed and unsigned operands
    issue16(1'b1, 16'h8000, 16'h8000);
    issue16(1'b0, 16'hFFFF, 16'hFFFF);
    issue16(1'b1, 16'hFFFF, 16'hFFFF);
    issue16(1'b1, 16'h7FFF, 16'h8000);
    for (int i = 0; i < 1000; i++) begin
      issue16(1'b1, 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 1000; i++) begin
      issue16(1'b0, 16'($urandom), 16'($urandom));
    end
    drain16();
    $display("W16 random run: %0d products observed", nvalid16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul_r4.md
# booth_mul_r4

Parametrised sequential radix-4 Booth multiplier, the next generation of the team's 8-bit radix-2 Booth unit. It multiplies two W-bit operands and returns a 2W-bit product, in either two's-complement or unsigned mode, which is selected per operation. It retires two multiplier bits per clock behind a start/busy/valid handshake. It sits beside the datapath as a multi-cycle arithmetic unit, and its result is held stable until the next operation is accepted.

## Interface
- W, default 8; operand width; must be even and at least 4.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- tc  in  1  1 = signed (two's-complement) operands, 0 = unsigned; sampled with start.
- X  in  W  multiplier; sampled with start.
- Y  in  W  multiplicand; sampled with start.
- busy  out  1  operation in progress.
- valid  out  1  one-cycle pulse: Z holds a new product.
- Z  out  2W  product; held until the next accepted start.

## Operation
- Extension: operands are extended internally to W+2 bits, sign-extended when tc=1 and zero-extended when tc=0. The digit count is D = W/2+1. For W=8, D=5.
- States:
  - IDLE: waiting for start.
  - RUN: one Booth digit per cycle; count runs 0..D-1.
- IDLE -> RUN on start=1. On that edge:
  - latch the extended Y;
  - load the accumulator with {(W+2) zeros, extended X, 1'b0};
  - set count=0 and busy=1.
- RUN, each cycle:
  - Recode acc[2:0] as the digit: 000/111 -> 0; 001/010 -> +Y; 011 -> +2Y; 100 -> -2Y; 101/110 -> -Y.
  - Add the digit's partial product into the upper W+3 bits of the accumulator, computed at W+3 bits wide.
  - Arithmetic-shift the accumulator right by 2.
  - Increment count.
- RUN -> IDLE on the edge where count=D-1 is processed. On that edge Z <= the low 2W bits of the final product, valid <= 1 and busy <= 0.
- start while busy=1 is ignored; it is neither queued nor does it corrupt the operation.
- start in the cycle valid=1 (state is IDLE) is accepted normally, which gives back-to-back operation.
- The result is exact modulo 2^2W. Signed results are correct over the full range, including -2^(W-1) × -2^(W-1). Unsigned results are correct up to (2^W-1)².
- Z is not modified during RUN; it keeps the previous product.

## Timing
- Reset values: busy=0, valid=0, Z=0, state=IDLE, count=0, accumulator=0.
- rst asserted mid-operation aborts immediately. The next cycle shows the reset values, and no valid pulse is produced for the aborted operation.
- rst takes priority over start in the same cycle.
- Latency: start is accepted at edge k. busy is high from edge k to edge k+D, and valid is high for exactly one cycle, from edge k+D to edge k+D+1.
- Throughput: one product every D cycles, with no idle bubble required between operations.
- valid is never high while busy is high.

## Structure
- Package booth_pkg holds:
  - state enum {IDLE, RUN};
  - Booth digit enum {ZERO, PY, P2Y, MY, M2Y};
  - a function mapping 3 bits to a digit.
- Sub-module booth_r4_digit (combinational): takes the 3-bit window and the extended Y, and produces the (W+3)-bit signed partial product.
- The top level holds the FSM, count, accumulator and output registers.

## Test plan
- W=8, tc=1: X=-128, Y=-128 -> after 5 cycles valid pulses, Z=16'h4000; busy high for exactly 5 cycles.
- W=8, tc=0: X=255, Y=255 -> Z=16'hFE01. Then tc=1 with the same bits (-1 × -1) -> Z=16'h0001.
- W=8, tc=1: X=-1, Y=127 -> Z=16'hFF81. Repeat start on the valid cycle with X=3, Y=-5 -> back-to-back, Z=16'hFFF1 five cycles later.
- Start pulse during RUN with different operands -> ignored; the first product is delivered and no second valid follows.
- rst asserted at count=2 -> next cycle busy=0, valid=0, Z=0; no valid ever follows for the aborted operation.
- W=16 instance, random signed and unsigned operands (≥1000 each) against a reference model -> all Z match; valid is always 9 cycles after start.
